// File: rtl/hazard_scoreboard.sv
// Issue-side hazard tracker for the ID stage: counts cycles until each in-flight
// destination is obtainable and holds ID while a used source is still pending.
module hazard_scoreboard #(
  parameter int NREG     = 16,
  parameter int LOAD_LAT = 1,
  parameter int WB_LAT   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [3:0]      src1,
  input  logic            src1_used,
  input  logic [3:0]      src2,
  input  logic            src2_used,
  input  logic [3:0]      id_dest,
  input  logic            id_wb_en,
  input  logic            id_is_load,
  input  logic            fwd_en,
  input  logic            freeze,
  output logic            hazard,
  output logic            issue,
  output logic [NREG-1:0] reg_busy,
  output logic [15:0]     stall_count
);

  localparam logic [1:0] LOAD_CNT = 2'(LOAD_LAT);
  localparam logic [1:0] WB_CNT   = 2'(WB_LAT);

  logic [1:0] cnt [NREG];
  logic [1:0] new_cnt;

  // Hazard looks only at the counts before this edge, so a self-dependency
  // waits on the old producer and never on its own fresh entry.
  assign hazard = id_valid & ((src1_used & (cnt[src1] != 2'd0)) |
                              (src2_used & (cnt[src2] != 2'd0)));
  assign issue  = id_valid & ~hazard & ~freeze;

  assign new_cnt = fwd_en ? (id_is_load ? LOAD_CNT : 2'd0) : WB_CNT;

  always_comb begin
    reg_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      reg_busy[r] = (cnt[r] != 2'd0);
    end
  end

  // The issuing instruction simply overwrites its destination entry; in-order
  // execution plus MEM-over-WB forwarding priority makes older entries moot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= 2'd0;
      end
      stall_count <= 16'd0;
    end else if (!freeze) begin
      for (int r = 0; r < NREG; r++) begin
        if (issue && id_wb_en && (id_dest == 4'(r))) begin
          cnt[r] <= new_cnt;
        end else if (cnt[r] != 2'd0) begin
          cnt[r] <= cnt[r] - 2'd1;
        end
      end
      if (hazard && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: each cycle's expected outputs are
// queued with the stimulus and popped/compared on the following falling edge.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  src1 = 4'd0;
  logic        src1_used = 1'b0;
  logic [3:0]  src2 = 4'd0;
  logic        src2_used = 1'b0;
  logic [3:0]  id_dest = 4'd0;
  logic        id_wb_en = 1'b0;
  logic        id_is_load = 1'b0;
  logic        fwd_en = 1'b1;
  logic        freeze = 1'b0;
  logic        hazard;
  logic        issue;
  logic [15:0] reg_busy;
  logic [15:0] stall_count;

  typedef struct packed {
    logic        h;
    logic        i;
    logic [15:0] b;
    logic [15:0] s;
  } exp_t;

  exp_t  expQ[$];
  int    checks = 0;
  int    failures = 0;
  string scen = "init";

  hazard_scoreboard #(.NREG(16), .LOAD_LAT(1), .WB_LAT(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .src1(src1), .src1_used(src1_used), .src2(src2), .src2_used(src2_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .fwd_en(fwd_en), .freeze(freeze),
    .hazard(hazard), .issue(issue), .reg_busy(reg_busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h at %0t", scen, tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("hazard", {15'd0, hazard}, {15'd0, e.h});
      checkOutput("issue", {15'd0, issue}, {15'd0, e.i});
      checkOutput("reg_busy", reg_busy, e.b);
      checkOutput("stall_count", stall_count, e.s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setInstr(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2,
                          input logic [3:0] d, input logic we, input logic ld);
    id_valid = v; src1 = s1; src1_used = u1; src2 = s2; src2_used = u2;
    id_dest = d; id_wb_en = we; id_is_load = ld;
  endtask

  task automatic applyStimulus(input logic fe, input logic fz, input logic r,
                               input logic eh, input logic ei,
                               input logic [15:0] eb, input logic [15:0] es);
    fwd_en = fe; freeze = fz; rst = r;
    expQ.push_back('{eh, ei, eb, es});
    tick();
  endtask

  task automatic resetCycles(input int n, input string name);
    scen = name;
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      setInstr(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
               4'($urandom), 1'($urandom), 1'($urandom));
      fwd_en = 1'($urandom);
      freeze = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset with random inputs, then state must be clean and issue follows id_valid
    resetCycles(2, "reset");
    setInstr(1, 4'd2, 1, 4'd11, 1, 4'd0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 16'h0000, 16'd0);

    // ALU producer with forwarding: dependent never stalls
    resetCycles(1, "alu_fwd");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 16'd0);

    // Load producer with forwarding: exactly one stall cycle
    resetCycles(1, "load_fwd");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd1, 0, 4'd3, 1, 4'd6, 1, 0);
    applyStimulus(1, 0, 0, 1, 0, 16'h0008, 16'd0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd1);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 16'd1);

    // No forwarding: dependent waits for the register file, three stalls
    resetCycles(1, "no_fwd");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd5, 1, 4'd0, 0, 4'd8, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 16'h0020, 16'd0);
    applyStimulus(0, 0, 0, 1, 0, 16'h0020, 16'd1);
    applyStimulus(0, 0, 0, 1, 0, 16'h0020, 16'd2);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd3);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'd3);

    // Freeze during the load stall: hazard persists, count and stall_count hold
    resetCycles(1, "freeze");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd7, 1, 4'd0, 0, 4'd10, 1, 0);
    applyStimulus(1, 1, 0, 1, 0, 16'h0080, 16'd0);
    applyStimulus(1, 1, 0, 1, 0, 16'h0080, 16'd0);
    applyStimulus(1, 0, 0, 1, 0, 16'h0080, 16'd0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0000, 16'd1);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 16'd1);

    // Reset in the middle of a stall discards the pending entry
    resetCycles(1, "mid_reset");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd9, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd0, 0, 4'd9, 1, 4'd12, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 16'h0200, 16'd0);
    applyStimulus(0, 0, 1, 1, 0, 16'h0200, 16'd1);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 16'd0);

    // Self-dependency stalls on the old count, then rewrites it; a later
    // fwd_en change does not rescale the entry already loaded
    resetCycles(1, "self_dep");
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd0);
    setInstr(1, 4'd1, 1, 4'd0, 0, 4'd1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 16'h0002, 16'd0);
    applyStimulus(0, 0, 0, 1, 0, 16'h0002, 16'd1);
    applyStimulus(0, 0, 0, 1, 0, 16'h0002, 16'd2);
    applyStimulus(0, 0, 0, 0, 1, 16'h0000, 16'd3);
    setInstr(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 1);
    applyStimulus(1, 0, 0, 0, 1, 16'h0002, 16'd3);
    setInstr(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0006, 16'd3);
    applyStimulus(1, 0, 0, 0, 0, 16'h0002, 16'd3);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 16'd3);

    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Issue-side hazard tracker for the ID stage of the 4-stage pipeline (ID → EXE → MEM → WB). It records every destination register write that is in flight and holds the instruction in ID until each source it reads is obtainable. A source is obtainable either through the MEM/WB forwarding path or, when forwarding is disabled, from the register file. It is the producer-side companion of the forwarding mux select logic. It guarantees that whenever an instruction leaves ID, the forwarding select logic or the register file can supply correct operands.

## Interface
Parameters:
- NREG, 16, number of architectural registers; register indices are 4 bits.
- LOAD_LAT, 1, extra cycles before a load result is forwardable beyond an ALU result.
- WB_LAT, 3, cycles from issue until the register file read in ID returns the new value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a valid instruction.
- src1  input  4  first source register index.
- src1_used  input  1  src1 is actually read.
- src2  input  4  second source register index.
- src2_used  input  1  src2 is actually read.
- id_dest  input  4  destination register of the ID instruction.
- id_wb_en  input  1  ID instruction writes id_dest.
- id_is_load  input  1  ID instruction is a memory load.
- fwd_en  input  1  forwarding path enabled.
- freeze  input  1  global pipeline hold (memory wait); the scoreboard holds all state.
- hazard  output  1  stall ID/IF and inject a bubble into EXE this cycle.
- issue  output  1  the ID instruction moves to EXE at the next edge.
- reg_busy  output  16  bit r is set when cnt[r] != 0.
- stall_count  output  16  saturating count of hazard-stall cycles.

## Operation
- State: cnt[0..15], each 2 bits, gives the cycles until the register value is obtainable. Also holds stall_count.
- hazard is combinational:
  - hazard = id_valid & ((src1_used & cnt[src1] != 0) | (src2_used & cnt[src2] != 0)).
  - It is evaluated against the current counts, before any update at this edge.
- issue = id_valid & ~hazard & ~freeze.
- Per-edge update of each cnt[r], when freeze = 0, in priority order:
  - If issue & id_wb_en & r == id_dest: cnt[r] ← (fwd_en ? (id_is_load ? LOAD_LAT : 0) : WB_LAT).
  - Else if cnt[r] != 0: cnt[r] ← cnt[r] − 1.
  - Else: hold.
- When freeze = 1, all cnt values and stall_count hold. hazard is still driven. issue = 0.
- The issuing instruction overwrites its destination count without regard to older entries. This is correct because execution is in order and the forwarding logic gives MEM priority over WB.
- Self-dependency (src == dest, e.g. R1 ← R1 + 1) stalls only on the old count. The new count is written afterwards.
- A change of fwd_en affects only instructions issued after the change. Counts already loaded are not rescaled.
- stall_count increments by 1 on each edge where hazard & ~freeze. It saturates at 0xFFFF and never wraps.
- id_wb_en = 0 (stores, compares, branches): no count is written.

## Timing
- Reset (rst = 1 at an edge):
  - All cnt ← 0 and stall_count ← 0.
  - From the next cycle: reg_busy = 0, hazard = 0, issue = id_valid.
- Reset mid-stall discards all pending entries. The stalled instruction issues the cycle after reset is released.
- A producer issued at edge t:
  - ALU result with fwd_en = 1: a dependent in ID during t+1 issues with no stall.
  - Load with fwd_en = 1: the dependent stalls 1 cycle and issues at edge t+2.
  - Either result with fwd_en = 0: the dependent stalls 3 cycles and issues at edge t+4.
- Each freeze cycle lengthens an outstanding stall by exactly one cycle.
- issue and hazard are never both 1.

## Test plan
- Reset: assert rst for 2 cycles with random inputs. Required after release: hazard = 0, reg_busy = 0x0000, stall_count = 0.
- fwd_en = 1: ADD R3 issues, then SUB reads src1 = R3. Required: hazard = 0 throughout, reg_busy = 0x0000, stall_count = 0.
- fwd_en = 1: LDR R3 issues, then ADD reads src2 = R3. Required:
  - hazard = 1 for exactly 1 cycle; reg_busy = 0x0008 during that cycle.
  - issue occurs the following cycle; stall_count = 1.
- fwd_en = 0: ADD R5 issues, then an instruction reads R5. Required:
  - hazard = 1 for 3 cycles; reg_busy[5] falls after the 3rd cycle.
  - stall_count = 3.
- fwd_en = 1: LDR R7, then a dependent with freeze = 1 for 2 cycles in the first stall cycle. Required:
  - hazard held for 3 cycles total; cnt[7] frozen.
  - stall_count = 1, since frozen cycles are not counted.
- fwd_en = 0: ADD R9, then assert rst during the 2nd stall cycle. Required: after release, reg_busy = 0, hazard = 0, and the dependent issues immediately.
